// File: rtl/alu_mac_seq_pkg.sv
// rtl/alu_mac_seq_pkg.sv - shared opmodes, defaults and helpers for the MAC sequencer
//
// Purpose: DSP48A1 opmode constants used by the sequencer, default build
//   parameters, the issue-kind enum and helpers that map it to an opmode and
//   derive the rounding constant fed to the wrapper's C port.
// Ports: none (package).

package alu_mac_seq_pkg;

  // Opmode layout: X = [1:0] (01 = M), Z = [3:2] (10 = P, 11 = C)
  localparam logic [7:0] OPM_MAC_INIT = 8'h0D;  // P = C + M
  localparam logic [7:0] OPM_MAC_ACC  = 8'h09;  // P = P + M
  localparam logic [7:0] OPM_MAC_HOLD = 8'h08;  // P = P

  localparam int DSP_LAT_DEFAULT   = 3;
  localparam int OUT_SHIFT_DEFAULT = 17;
  localparam int OUT_W_DEFAULT     = 18;
  localparam int OUT_DEPTH_DEFAULT = 2;

  typedef enum logic [1:0] {
    ISSUE_HOLD = 2'd0,
    ISSUE_INIT = 2'd1,
    ISSUE_ACC  = 2'd2
  } issue_e;

  function automatic logic [7:0] opmode_of(input issue_e kind);
    case (kind)
      ISSUE_INIT: return OPM_MAC_INIT;
      ISSUE_ACC:  return OPM_MAC_ACC;
      default:    return OPM_MAC_HOLD;
    endcase
  endfunction

  // Half an output LSB, so the arithmetic shift rounds half-up instead of flooring.
  function automatic logic [47:0] round_const(input int shift);
    if (shift <= 0) return '0;
    return 48'd1 << (shift - 1);
  endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// rtl/alu_res_fifo.sv - first-word-fall-through result FIFO
//
// Purpose: small synchronous FWFT FIFO holding finished burst results until
//   the output stage takes them. Head word is visible on m_tdata whenever
//   m_tvalid is high.
// Ports:
//   clk, reset          clock, synchronous active-high reset (empties the FIFO)
//   s_tvalid/s_tready   write handshake, s_tdata write word
//   m_tvalid/m_tready   read handshake, m_tdata head word

module alu_res_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s_tvalid,
  output logic         s_tready,
  input  logic [W-1:0] s_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic [W-1:0] m_tdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign s_tready = (count != CW'(DEPTH));
  assign m_tvalid = (count != '0);
  assign m_tdata  = mem[rd_ptr];
  assign push     = s_tvalid && s_tready;
  assign pop      = m_tvalid && m_tready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_tdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_mac_seq.sv
// rtl/alu_mac_seq.sv - burst dot-product sequencer in front of a DSP48A1 wrapper
//
// Purpose: registers (a,b) operand beats into the pipelined multiplier/post-adder
//   wrapper, selecting init/accumulate/hold opmodes so each burst (ended by
//   in_last) collapses into one sum. A tag pipe marks when the wrapper's p holds a
//   finished sum; that sum is rounded, shifted, saturated and queued, then
//   presented through a registered valid/ready output. Credits bound the number
//   of unretired bursts so the result queue can never overflow.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   in_valid/in_ready, in_a, in_b  operand beat handshake and signed operands
//   in_last                        last beat of the burst
//   dsp_op, dsp_a, dsp_b, dsp_c    registered drive to the wrapper
//   dsp_p                          wrapper accumulator output
//   out_valid/out_ready, out_data  result handshake and signed result
//   ovf                            sticky saturation flag

module alu_mac_seq
  import alu_mac_seq_pkg::*;
#(
  parameter int DSP_LAT   = DSP_LAT_DEFAULT,
  parameter int OUT_SHIFT = OUT_SHIFT_DEFAULT,
  parameter int OUT_W     = OUT_W_DEFAULT,
  parameter int OUT_DEPTH = OUT_DEPTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [17:0]      in_a,
  input  logic signed [17:0]      in_b,
  input  logic                    in_last,
  output logic [7:0]              dsp_op,
  output logic signed [17:0]      dsp_a,
  output logic signed [17:0]      dsp_b,
  output logic [47:0]             dsp_c,
  input  logic [47:0]             dsp_p,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    ovf
);

  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam logic [47:0] ROUND_C = round_const(OUT_SHIFT);
  localparam logic signed [47:0] SAT_MAX = (48'sd1 <<< (OUT_W - 1)) - 48'sd1;
  localparam logic signed [47:0] SAT_MIN = -(48'sd1 <<< (OUT_W - 1));

  // ---------------- issue ----------------
  logic   accept;
  logic   accept_last;
  logic   first_beat;
  logic   issue_last;
  issue_e issue_kind;

  assign accept      = in_valid && in_ready;
  assign accept_last = accept && in_last;

  always_comb begin
    issue_kind = ISSUE_HOLD;
    if (accept) issue_kind = first_beat ? ISSUE_INIT : ISSUE_ACC;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dsp_op     <= '0;
      dsp_a      <= '0;
      dsp_b      <= '0;
      dsp_c      <= '0;
      issue_last <= 1'b0;
      first_beat <= 1'b1;
    end else begin
      dsp_op     <= opmode_of(issue_kind);
      dsp_c      <= ROUND_C;
      issue_last <= accept_last;
      // Operands only matter on INIT/ACC cycles; hold otherwise to limit toggling.
      if (accept) begin
        dsp_a      <= in_a;
        dsp_b      <= in_b;
        first_beat <= in_last;
      end
    end
  end

  // ---------------- tag pipe ----------------
  // tag[i] follows the issue cycle of a last beat; the oldest bit lines up with
  // the cycle in which dsp_p carries that burst's complete sum.
  logic [DSP_LAT-1:0] tag;
  logic               capture;

  always_ff @(posedge clk) begin
    if (reset) begin
      tag <= '0;
    end else begin
      tag[0] <= issue_last;
      for (int i = 1; i < DSP_LAT; i++) tag[i] <= tag[i-1];
    end
  end

  assign capture = tag[DSP_LAT-1];

  // ---------------- round / saturate ----------------
  logic signed [47:0]      sum_shifted;
  logic                    sat_hi;
  logic                    sat_lo;
  logic signed [OUT_W-1:0] res;

  assign sum_shifted = $signed(dsp_p) >>> OUT_SHIFT;
  assign sat_hi      = (sum_shifted > SAT_MAX);
  assign sat_lo      = (sum_shifted < SAT_MIN);

  always_comb begin
    res = sum_shifted[OUT_W-1:0];
    if (sat_hi)      res = SAT_MAX[OUT_W-1:0];
    else if (sat_lo) res = SAT_MIN[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset)                          ovf <= 1'b0;
    else if (capture && (sat_hi || sat_lo)) ovf <= 1'b1;
  end

  // ---------------- result queue and output stage ----------------
  logic             fifo_s_tready;
  logic             fifo_m_tvalid;
  logic             fifo_m_tready;
  logic [OUT_W-1:0] fifo_m_tdata;
  logic             out_pop;

  alu_res_fifo #(
    .W     (OUT_W),
    .DEPTH (OUT_DEPTH)
  ) u_res_fifo (
    .clk      (clk),
    .reset    (reset),
    .s_tvalid (capture),
    .s_tready (fifo_s_tready),
    .s_tdata  (res),
    .m_tvalid (fifo_m_tvalid),
    .m_tready (fifo_m_tready),
    .m_tdata  (fifo_m_tdata)
  );

  assign out_pop       = out_valid && out_ready;
  assign fifo_m_tready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (fifo_m_tready) begin
      out_valid <= fifo_m_tvalid;
      if (fifo_m_tvalid) out_data <= $signed(fifo_m_tdata);
    end
  end

  // A result can't be dropped: credits cap unretired bursts at the queue depth.
  assert property (@(posedge clk) disable iff (reset) capture |-> fifo_s_tready);

  // ---------------- credits ----------------
  // One credit per unretired burst; a burst retires when its result is popped.
  logic [CW-1:0] credits;
  logic [CW-1:0] credits_nxt;

  always_comb begin
    credits_nxt = credits;
    case ({accept_last, out_pop})
      2'b10:   credits_nxt = credits - CW'(1);
      2'b01:   credits_nxt = credits + CW'(1);
      default: credits_nxt = credits;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credits  <= CW'(OUT_DEPTH);
      in_ready <= 1'b0;
    end else begin
      credits  <= credits_nxt;
      in_ready <= (credits_nxt != '0);
    end
  end

endmodule

// File: tb/tb_alu_mac_seq.sv
// tb/tb_alu_mac_seq.sv - directed bench for alu_mac_seq with behavioural DSP48A1 wrappers

module tb_alu_mac_seq;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic signed [17:0] in_a;
  logic signed [17:0] in_b;
  logic in_last;
  logic out_ready;

  logic               in_ready  [2];
  logic [7:0]         dsp_op    [2];
  logic signed [17:0] dsp_a     [2];
  logic signed [17:0] dsp_b     [2];
  logic [47:0]        dsp_c     [2];
  logic               out_valid [2];
  logic signed [17:0] out_data  [2];
  logic               ovf       [2];

  // behavioural wrapper state: a/b/op/c register, M register, P register
  logic signed [17:0] da1 [2];
  logic signed [17:0] db1 [2];
  logic [7:0]         op1 [2];
  logic [7:0]         op2 [2];
  logic signed [47:0] c1  [2];
  logic signed [47:0] c2  [2];
  logic signed [47:0] m2  [2];
  logic signed [47:0] pr  [2];
  logic signed [47:0] zsel [2];
  logic signed [47:0] xsel [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_mac_seq dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .dsp_op(dsp_op[0]), .dsp_a(dsp_a[0]), .dsp_b(dsp_b[0]), .dsp_c(dsp_c[0]),
    .dsp_p(pr[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_data(out_data[0]), .ovf(ovf[0])
  );

  alu_mac_seq #(.OUT_SHIFT(0)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .dsp_op(dsp_op[1]), .dsp_a(dsp_a[1]), .dsp_b(dsp_b[1]), .dsp_c(dsp_c[1]),
    .dsp_p(pr[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_data(out_data[1]), .ovf(ovf[1])
  );

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      zsel[k] = '0;
      xsel[k] = '0;
      case (op2[k][3:2])
        2'b10:   zsel[k] = pr[k];
        2'b11:   zsel[k] = c2[k];
        default: zsel[k] = '0;
      endcase
      if (op2[k][1:0] == 2'b01) xsel[k] = m2[k];
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        da1[k] <= '0; db1[k] <= '0; op1[k] <= '0; op2[k] <= '0;
        c1[k] <= '0; c2[k] <= '0; m2[k] <= '0; pr[k] <= '0;
      end else begin
        da1[k] <= dsp_a[k];
        db1[k] <= dsp_b[k];
        op1[k] <= dsp_op[k];
        c1[k]  <= dsp_c[k];
        m2[k]  <= 48'(da1[k]) * 48'(db1[k]);
        op2[k] <= op1[k];
        c2[k]  <= c1[k];
        pr[k]  <= zsel[k] + xsel[k];
      end
    end
  end

  // Present a beat at a negedge and return at the negedge after it is accepted.
  task automatic send_beat(input logic signed [17:0] a, input logic signed [17:0] b,
                           input logic last);
    int n;
    n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    while (!in_ready[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[0]) begin
      checks++; errors++;
      $display("FAIL beat_accept: in_ready=0 required 1 within 50 cycles");
    end
    @(negedge clk);
  endtask

  // Wait (bounded) for the next result and let it pop; lat = negedges waited, -1 on timeout.
  task automatic get_result(output logic signed [17:0] d0, output logic signed [17:0] d1,
                            output int lat);
    lat = -1; d0 = '0; d1 = '0;
    in_valid = 1'b0; in_last = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (out_valid[0]) begin
        d0 = out_data[0]; d1 = out_data[1]; lat = n;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (dsp_op[0] !== 8'h00 || dsp_a[0] !== 18'sd0 || dsp_c[0] !== 48'd0) begin
      errors++; $display("FAIL reset_dsp: op=%h a=%0d c=%0d required 0 0 0", dsp_op[0], dsp_a[0], dsp_c[0]); end
    checks++; if (in_ready[0] !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready[0]); end
    checks++; if (out_valid[0] !== 1'b0 || out_data[0] !== 18'sd0 || ovf[0] !== 1'b0) begin
      errors++; $display("FAIL reset_out: valid=%b data=%0d ovf=%b required 0 0 0", out_valid[0], out_data[0], ovf[0]); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready[0] !== 1'b1) begin
      errors++; $display("FAIL post_reset_in_ready: got %b required 1", in_ready[0]); end
    checks++; if (dsp_op[0] !== 8'h08) begin
      errors++; $display("FAIL idle_opmode: got %h required 08", dsp_op[0]); end
    checks++; if (dsp_c[0] !== 48'd65536 || dsp_c[1] !== 48'd0) begin
      errors++; $display("FAIL round_const: got %0d/%0d required 65536/0", dsp_c[0], dsp_c[1]); end
  endtask

  task automatic test_single();
    logic signed [17:0] d0, d1;
    int lat;
    send_beat(18'sd65536, 18'sd65536, 1'b1);
    get_result(d0, d1, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL single_latency: got %0d required 5", lat); end
    checks++; if (d0 !== 18'sd32768) begin errors++; $display("FAIL single_data: got %0d required 32768", d0); end
    checks++; if (ovf[0] !== 1'b0) begin errors++; $display("FAIL single_ovf: got %b required 0", ovf[0]); end
  endtask

  task automatic test_dot();
    logic signed [17:0] d0, d1;
    int lat;
    send_beat(18'sd1000, 18'sd100, 1'b0);
    send_beat(-18'sd2000, 18'sd50, 1'b0);
    send_beat(18'sd300, -18'sd7, 1'b1);
    get_result(d0, d1, lat);
    checks++; if (lat !== 5 || d0 !== 18'sd0) begin
      errors++; $display("FAIL dot_shift17: got %0d lat %0d required 0 lat 5", d0, lat); end
    checks++; if (d1 !== -18'sd2100) begin
      errors++; $display("FAIL dot_shift0: got %0d required -2100", d1); end
  endtask

  task automatic test_rounding();
    logic signed [17:0] ta [3] = '{18'sd1, 18'sd1, -18'sd1};
    logic signed [17:0] tb [3] = '{18'sd65536, 18'sd65535, 18'sd65536};
    logic signed [17:0] te [3] = '{18'sd1, 18'sd0, 18'sd0};
    logic signed [17:0] d0, d1;
    int lat;
    for (int i = 0; i < 3; i++) begin
      send_beat(ta[i], tb[i], 1'b1);
      get_result(d0, d1, lat);
      checks++; if (lat < 0 || d0 !== te[i]) begin
        errors++; $display("FAIL round_%0d: got %0d lat %0d required %0d", i, d0, lat, te[i]); end
    end
  endtask

  task automatic test_gaps();
    logic signed [17:0] d0, d1;
    int lat;
    send_beat(18'sd65536, 18'sd1000, 1'b0);
    send_beat(18'sd65536, 18'sd2000, 1'b0);
    send_beat(18'sd65536, 18'sd3000, 1'b0);
    send_beat(18'sd65536, 18'sd4000, 1'b1);
    get_result(d0, d1, lat);
    checks++; if (lat < 0 || d0 !== 18'sd5000) begin
      errors++; $display("FAIL gapless_sum: got %0d required 5000", d0); end
    send_beat(18'sd65536, 18'sd1000, 1'b0);
    send_beat(18'sd65536, 18'sd2000, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    send_beat(18'sd65536, 18'sd3000, 1'b0);
    send_beat(18'sd65536, 18'sd4000, 1'b1);
    get_result(d0, d1, lat);
    checks++; if (lat < 0 || d0 !== 18'sd5000) begin
      errors++; $display("FAIL gapped_sum: got %0d required 5000", d0); end
  endtask

  task automatic test_backpressure();
    logic signed [17:0] d0, d1;
    int lat;
    out_ready = 1'b0;
    send_beat(18'sd65536, 18'sd65536, 1'b1);
    send_beat(18'sd65536, 18'sd32768, 1'b1);
    checks++; if (in_ready[0] !== 1'b0) begin
      errors++; $display("FAIL bp_credit_stall: in_ready=%b required 0", in_ready[0]); end
    in_valid = 1'b1; in_a = 18'sd65536; in_b = 18'sd16384; in_last = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (in_ready[0] !== 1'b0) begin
      errors++; $display("FAIL bp_still_stalled: in_ready=%b required 0", in_ready[0]); end
    checks++; if (out_valid[0] !== 1'b1 || out_data[0] !== 18'sd32768) begin
      errors++; $display("FAIL bp_hold_first: valid=%b data=%0d required 1 32768", out_valid[0], out_data[0]); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready[0] !== 1'b1) begin
      errors++; $display("FAIL bp_credit_return: in_ready=%b required 1", in_ready[0]); end
    checks++; if (out_valid[0] !== 1'b1 || out_data[0] !== 18'sd16384) begin
      errors++; $display("FAIL bp_second: valid=%b data=%0d required 1 16384", out_valid[0], out_data[0]); end
    @(negedge clk);
    get_result(d0, d1, lat);
    checks++; if (lat < 0 || d0 !== 18'sd8192) begin
      errors++; $display("FAIL bp_third: got %0d lat %0d required 8192", d0, lat); end
  endtask

  task automatic test_saturation();
    logic signed [17:0] d0, d1;
    int lat;
    repeat (3) send_beat(18'sd131071, 18'sd131071, 1'b0);
    send_beat(18'sd131071, 18'sd131071, 1'b1);
    get_result(d0, d1, lat);
    checks++; if (lat < 0 || d0 !== 18'sd131071) begin
      errors++; $display("FAIL sat_pos: got %0d required 131071", d0); end
    checks++; if (ovf[0] !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b required 1", ovf[0]); end
    repeat (3) send_beat(18'sd131071, -18'sd131072, 1'b0);
    send_beat(18'sd131071, -18'sd131072, 1'b1);
    get_result(d0, d1, lat);
    checks++; if (lat < 0 || d0 !== -18'sd131072) begin
      errors++; $display("FAIL sat_neg: got %0d required -131072", d0); end
    send_beat(18'sd65536, 18'sd65536, 1'b1);
    get_result(d0, d1, lat);
    checks++; if (d0 !== 18'sd32768 || ovf[0] !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: data=%0d ovf=%b required 32768 1", d0, ovf[0]); end
  endtask

  task automatic test_reset_mid();
    logic signed [17:0] d0, d1;
    int lat;
    int seen;
    send_beat(18'sd65536, 18'sd65536, 1'b0);
    send_beat(18'sd65536, 18'sd65536, 1'b1);
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    checks++; if (in_ready[0] !== 1'b0 || ovf[0] !== 1'b0) begin
      errors++; $display("FAIL midreset_state: in_ready=%b ovf=%b required 0 0", in_ready[0], ovf[0]); end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      if (out_valid[0]) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin
      errors++; $display("FAIL midreset_no_output: %0d valid cycles required 0", seen); end
    checks++; if (in_ready[0] !== 1'b1) begin
      errors++; $display("FAIL midreset_in_ready: got %b required 1", in_ready[0]); end
    send_beat(18'sd1, 18'sd65536, 1'b1);
    get_result(d0, d1, lat);
    checks++; if (lat !== 5 || d0 !== 18'sd1) begin
      errors++; $display("FAIL midreset_next: got %0d lat %0d required 1 lat 5", d0, lat); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_dot();
    test_rounding();
    test_gaps();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
